// File: rtl/ext_mem_arbiter.sv
// ext_mem_arbiter: shares one external memory line port between the
// instruction-fetch requester (port I) and the L1 data cache requester (port D).
// Requests are registered onto the mem_* pins; ack and read data are routed
// back to the granted port only, and a hung transaction is aborted after
// TIMEOUT_CYCLES grant cycles (0 disables the abort).
// Optional macro ARB_ROUND_ROBIN_EN: ties alternate between the ports instead
// of D always winning.
module ext_mem_arbiter #(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 256,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] i_addr_i,
  input  logic                  i_cs_i,
  input  logic                  i_we_i,
  input  logic [DATA_WIDTH-1:0] i_data_i,
  output logic [DATA_WIDTH-1:0] i_data_o,
  output logic                  i_ack_o,
  input  logic [ADDR_WIDTH-1:0] d_addr_i,
  input  logic                  d_cs_i,
  input  logic                  d_we_i,
  input  logic [DATA_WIDTH-1:0] d_data_i,
  output logic [DATA_WIDTH-1:0] d_data_o,
  output logic                  d_ack_o,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  output logic                  mem_cs_o,
  output logic                  mem_we_o,
  output logic [DATA_WIDTH-1:0] mem_data_o,
  input  logic [DATA_WIDTH-1:0] mem_data_i,
  input  logic                  mem_ack_i,
  output logic                  busy_o,
  output logic                  timeout_o
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT_I = 2'd1,
    GRANT_D = 2'd2
  } state_t;

  // The counter only has to reach TIMEOUT_CYCLES-1, so clog2(TIMEOUT_CYCLES) bits suffice.
  localparam int CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST =
    (TIMEOUT_CYCLES > 0) ? CNT_W'(TIMEOUT_CYCLES - 1) : '0;

  state_t                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic                  mem_cs_q, mem_cs_d;
  logic                  mem_we_q, mem_we_d;
  logic [DATA_WIDTH-1:0] mem_data_q, mem_data_d;
  logic                  pick_d;
  logic                  tmo_hit;
  logic                  done;
  logic                  grant_i;
  logic                  grant_d;

`ifdef ARB_ROUND_ROBIN_EN
  // Pointer names the port that wins the next tie: 0 = I, 1 = D.
  logic ptr_q, ptr_d;
`endif

  // Choose the winner among the ports requesting in IDLE.
  always_comb begin
    pick_d = 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
    pick_d = d_cs_i && (!i_cs_i || ptr_q);
`else
    pick_d = d_cs_i;
`endif
  end

  // Abort detection and completion/routing back to the granted requester.
  always_comb begin
    grant_i   = (state_q == GRANT_I);
    grant_d   = (state_q == GRANT_D);
    tmo_hit   = (TIMEOUT_CYCLES > 0) && (grant_i || grant_d) &&
                (cnt_q == CNT_LAST) && !mem_ack_i;
    done      = mem_ack_i || tmo_hit;
    i_ack_o   = grant_i && done;
    d_ack_o   = grant_d && done;
    i_data_o  = (grant_i && mem_ack_i) ? mem_data_i : '0;
    d_data_o  = (grant_d && mem_ack_i) ? mem_data_i : '0;
    timeout_o = tmo_hit;
    busy_o    = (state_q != IDLE);
  end

  // Next-state logic: grant from IDLE, hold the memory side until done.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    mem_addr_d = mem_addr_q;
    mem_cs_d   = mem_cs_q;
    mem_we_d   = mem_we_q;
    mem_data_d = mem_data_q;
`ifdef ARB_ROUND_ROBIN_EN
    ptr_d      = ptr_q;
`endif
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (i_cs_i || d_cs_i) begin
          mem_cs_d = 1'b1;
          if (pick_d) begin
            mem_addr_d = d_addr_i;
            mem_we_d   = d_we_i;
            mem_data_d = d_data_i;
            state_d    = GRANT_D;
`ifdef ARB_ROUND_ROBIN_EN
            ptr_d      = 1'b0;
`endif
          end else begin
            mem_addr_d = i_addr_i;
            mem_we_d   = i_we_i;
            mem_data_d = i_data_i;
            state_d    = GRANT_I;
`ifdef ARB_ROUND_ROBIN_EN
            ptr_d      = 1'b1;
`endif
          end
        end
      end
      GRANT_I, GRANT_D: begin
        if (done) begin
          state_d  = IDLE;
          mem_cs_d = 1'b0;
          mem_we_d = 1'b0;
          cnt_d    = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d  = IDLE;
        mem_cs_d = 1'b0;
        mem_we_d = 1'b0;
        cnt_d    = '0;
      end
    endcase
  end

  // State, counter and registered memory-side outputs with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      mem_addr_q <= '0;
      mem_cs_q   <= 1'b0;
      mem_we_q   <= 1'b0;
      mem_data_q <= '0;
`ifdef ARB_ROUND_ROBIN_EN
      ptr_q      <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      mem_addr_q <= mem_addr_d;
      mem_cs_q   <= mem_cs_d;
      mem_we_q   <= mem_we_d;
      mem_data_q <= mem_data_d;
`ifdef ARB_ROUND_ROBIN_EN
      ptr_q      <= ptr_d;
`endif
    end
  end

  assign mem_addr_o = mem_addr_q;
  assign mem_cs_o   = mem_cs_q;
  assign mem_we_o   = mem_we_q;
  assign mem_data_o = mem_data_q;

endmodule

// File: tb/tb_ext_mem_arbiter.sv
// Directed testbench for ext_mem_arbiter, built with TIMEOUT_CYCLES=8.
// Expectations for tie breaking follow ARB_ROUND_ROBIN_EN when it is defined.
module tb_ext_mem_arbiter;

  logic         clk;
  logic         rst;
  logic [31:0]  i_addr_i;
  logic         i_cs_i;
  logic         i_we_i;
  logic [255:0] i_data_i;
  logic [255:0] i_data_o;
  logic         i_ack_o;
  logic [31:0]  d_addr_i;
  logic         d_cs_i;
  logic         d_we_i;
  logic [255:0] d_data_i;
  logic [255:0] d_data_o;
  logic         d_ack_o;
  logic [31:0]  mem_addr_o;
  logic         mem_cs_o;
  logic         mem_we_o;
  logic [255:0] mem_data_o;
  logic [255:0] mem_data_i;
  logic         mem_ack_i;
  logic         busy_o;
  logic         timeout_o;

  int vectors;
  int errors;

  logic [255:0] pat_a5;
  logic [255:0] pat_1234;
  logic [255:0] pat_ff;
  logic [255:0] pat_5a;

  ext_mem_arbiter #(
    .ADDR_WIDTH    (32),
    .DATA_WIDTH    (256),
    .TIMEOUT_CYCLES(8)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .i_addr_i  (i_addr_i),
    .i_cs_i    (i_cs_i),
    .i_we_i    (i_we_i),
    .i_data_i  (i_data_i),
    .i_data_o  (i_data_o),
    .i_ack_o   (i_ack_o),
    .d_addr_i  (d_addr_i),
    .d_cs_i    (d_cs_i),
    .d_we_i    (d_we_i),
    .d_data_i  (d_data_i),
    .d_data_o  (d_data_o),
    .d_ack_o   (d_ack_o),
    .mem_addr_o(mem_addr_o),
    .mem_cs_o  (mem_cs_o),
    .mem_we_o  (mem_we_o),
    .mem_data_o(mem_data_o),
    .mem_data_i(mem_data_i),
    .mem_ack_i (mem_ack_i),
    .busy_o    (busy_o),
    .timeout_o (timeout_o)
  );

  // Free-running 10-unit clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Hard stop in case the directed sequence never completes.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: observed no finish, expected finish before time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  // Advance to 1 unit after the next rising edge, where inputs are updated.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive the memory-side response inputs.
  task automatic applyStimulus(input logic ack, input logic [255:0] rdata);
    mem_ack_i  = ack;
    mem_data_i = rdata;
  endtask

  // Compare one observed value against its expected value, 2 units after the edge.
  task automatic checkOutput(input string tag, input logic [255:0] obs,
                             input logic [255:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    vectors  = 0;
    errors   = 0;
    pat_a5   = {32{8'hA5}};
    pat_1234 = {16{16'h1234}};
    pat_ff   = {32{8'hFF}};
    pat_5a   = {32{8'h5A}};

    rst = 1'b1;
    i_addr_i = '0; i_cs_i = 1'b0; i_we_i = 1'b0; i_data_i = '0;
    d_addr_i = '0; d_cs_i = 1'b0; d_we_i = 1'b0; d_data_i = '0;
    applyStimulus(1'b0, '0);

    // ---- reset state
    tick(); tick();
    #1;
    checkOutput("rst_mem_cs", mem_cs_o, 0);
    checkOutput("rst_mem_we", mem_we_o, 0);
    checkOutput("rst_mem_addr", mem_addr_o, 0);
    checkOutput("rst_mem_data", mem_data_o, 0);
    checkOutput("rst_busy", busy_o, 0);
    checkOutput("rst_timeout", timeout_o, 0);
    checkOutput("rst_i_ack", i_ack_o, 0);
    checkOutput("rst_d_ack", d_ack_o, 0);
    rst = 1'b0;
    tick();

    // ---- single D read, ack 5 cycles after mem_cs rises
    $display("[TB] single D read");
    d_cs_i = 1'b1; d_we_i = 1'b0; d_addr_i = 32'h0000_0400;
    #1;
    checkOutput("rd_req_cycle_cs", mem_cs_o, 0);
    tick(); #1;
    checkOutput("rd_mem_cs", mem_cs_o, 1);
    checkOutput("rd_mem_addr", mem_addr_o, 32'h400);
    checkOutput("rd_mem_we", mem_we_o, 0);
    checkOutput("rd_busy", busy_o, 1);
    for (int k = 0; k < 4; k++) begin
      tick(); #1;
      checkOutput("rd_wait_d_ack", d_ack_o, 0);
      checkOutput("rd_wait_addr", mem_addr_o, 32'h400);
      checkOutput("rd_wait_timeout", timeout_o, 0);
    end
    tick();
    applyStimulus(1'b1, pat_a5);
    #1;
    checkOutput("rd_d_ack", d_ack_o, 1);
    checkOutput("rd_d_data", d_data_o, pat_a5);
    checkOutput("rd_i_ack", i_ack_o, 0);
    checkOutput("rd_i_data", i_data_o, 0);
    tick();
    applyStimulus(1'b0, '0);
    d_cs_i = 1'b0;
    #1;
    checkOutput("rd_after_cs", mem_cs_o, 0);
    checkOutput("rd_after_busy", busy_o, 0);
    checkOutput("rd_after_d_ack", d_ack_o, 0);

    // ---- single I write
    $display("[TB] single I write");
    i_cs_i = 1'b1; i_we_i = 1'b1; i_addr_i = 32'h20; i_data_i = pat_1234;
    tick(); #1;
    checkOutput("wr_mem_cs", mem_cs_o, 1);
    checkOutput("wr_mem_we", mem_we_o, 1);
    checkOutput("wr_mem_addr", mem_addr_o, 32'h20);
    checkOutput("wr_mem_data", mem_data_o, pat_1234);
    tick(); #1;
    checkOutput("wr_hold_data", mem_data_o, pat_1234);
    checkOutput("wr_hold_i_ack", i_ack_o, 0);
    tick();
    applyStimulus(1'b1, '0);
    #1;
    checkOutput("wr_i_ack", i_ack_o, 1);
    checkOutput("wr_d_ack", d_ack_o, 0);
    tick();
    applyStimulus(1'b0, '0);
    i_cs_i = 1'b0; i_we_i = 1'b0;
    #1;
    checkOutput("wr_after_cs", mem_cs_o, 0);
    checkOutput("wr_after_we", mem_we_o, 0);
    checkOutput("wr_after_i_ack", i_ack_o, 0);

    // ---- tie: D first (fixed priority; round robin pointer also names D here)
    $display("[TB] simultaneous requests");
    i_cs_i = 1'b1; i_addr_i = 32'h200;
    d_cs_i = 1'b1; d_addr_i = 32'h100;
    tick(); #1;
    checkOutput("tie1_addr", mem_addr_o, 32'h100);
    tick();
    applyStimulus(1'b1, pat_5a);
    #1;
    checkOutput("tie1_d_ack", d_ack_o, 1);
    checkOutput("tie1_i_ack", i_ack_o, 0);
    checkOutput("tie1_i_data", i_data_o, 0);
    tick();
    applyStimulus(1'b0, '0);
    d_cs_i = 1'b0;
    #1;
    checkOutput("tie_gap_cs", mem_cs_o, 0);
    checkOutput("tie_gap_busy", busy_o, 0);
    tick(); #1;
    checkOutput("tie2_cs", mem_cs_o, 1);
    checkOutput("tie2_addr", mem_addr_o, 32'h200);
    tick();
    applyStimulus(1'b1, pat_5a);
    #1;
    checkOutput("tie2_i_ack", i_ack_o, 1);
    checkOutput("tie2_i_data", i_data_o, pat_5a);
    checkOutput("tie2_d_ack", d_ack_o, 0);
    tick();
    applyStimulus(1'b0, '0);
    i_cs_i = 1'b0;

    // ---- timeout on D with I arriving mid-grant
    $display("[TB] timeout");
    d_cs_i = 1'b1; d_addr_i = 32'h300;
    tick();
    applyStimulus(1'b0, pat_ff);
    i_cs_i = 1'b1; i_addr_i = 32'h240; i_we_i = 1'b0;
    #1;
    checkOutput("to_c1_addr", mem_addr_o, 32'h300);
    checkOutput("to_c1_timeout", timeout_o, 0);
    for (int k = 2; k <= 7; k++) begin
      tick(); #1;
      checkOutput("to_wait_timeout", timeout_o, 0);
      checkOutput("to_wait_d_ack", d_ack_o, 0);
      checkOutput("to_wait_addr", mem_addr_o, 32'h300);
    end
    tick(); #1;
    checkOutput("to_c8_timeout", timeout_o, 1);
    checkOutput("to_c8_d_ack", d_ack_o, 1);
    checkOutput("to_c8_d_data", d_data_o, 0);
    checkOutput("to_c8_i_ack", i_ack_o, 0);
    tick();
    d_cs_i = 1'b0;
    #1;
    checkOutput("to_idle_cs", mem_cs_o, 0);
    checkOutput("to_idle_busy", busy_o, 0);
    checkOutput("to_idle_timeout", timeout_o, 0);
    tick(); #1;
    checkOutput("to_next_cs", mem_cs_o, 1);
    checkOutput("to_next_addr", mem_addr_o, 32'h240);
    for (int k = 2; k <= 7; k++) begin
      tick(); #1;
      checkOutput("ack_last_wait_i_ack", i_ack_o, 0);
    end
    tick();
    applyStimulus(1'b1, pat_a5);
    #1;
    checkOutput("ack_last_timeout", timeout_o, 0);
    checkOutput("ack_last_i_ack", i_ack_o, 1);
    checkOutput("ack_last_i_data", i_data_o, pat_a5);
    tick();
    applyStimulus(1'b0, '0);
    i_cs_i = 1'b0;

    // ---- reset in the 3rd GRANT_D cycle, late ack afterwards
    $display("[TB] reset mid-grant");
    tick();
    d_cs_i = 1'b1; d_addr_i = 32'h500; d_we_i = 1'b1; d_data_i = pat_ff;
    tick(); tick(); tick();
    rst = 1'b1;
    #1;
    checkOutput("rstm_busy_before", busy_o, 1);
    checkOutput("rstm_d_ack_before", d_ack_o, 0);
    tick();
    rst = 1'b0;
    d_cs_i = 1'b0; d_we_i = 1'b0;
    #1;
    checkOutput("rstm_cs", mem_cs_o, 0);
    checkOutput("rstm_we", mem_we_o, 0);
    checkOutput("rstm_addr", mem_addr_o, 0);
    checkOutput("rstm_data", mem_data_o, 0);
    checkOutput("rstm_busy", busy_o, 0);
    tick();
    applyStimulus(1'b1, pat_a5);
    #1;
    checkOutput("rstm_late_d_ack", d_ack_o, 0);
    checkOutput("rstm_late_i_ack", i_ack_o, 0);
    checkOutput("rstm_late_d_data", d_data_o, 0);
    tick();
    applyStimulus(1'b0, '0);
    #1;
    checkOutput("rstm_after_cs", mem_cs_o, 0);
    checkOutput("rstm_after_busy", busy_o, 0);

    // ---- both ports requesting continuously for four transactions
    $display("[TB] continuous requests");
    i_cs_i = 1'b1; i_addr_i = 32'h1000;
    d_cs_i = 1'b1; d_addr_i = 32'h2000;
    for (int k = 0; k < 4; k++) begin
      logic [31:0] exp_addr;
      logic        exp_d;
`ifdef ARB_ROUND_ROBIN_EN
      exp_d = (k % 2) == 1;
`else
      exp_d = 1'b1;
`endif
      exp_addr = exp_d ? 32'h2000 : 32'h1000;
      tick();
      applyStimulus(1'b1, pat_5a);
      #1;
      checkOutput("cont_addr", mem_addr_o, exp_addr);
      checkOutput("cont_d_ack", d_ack_o, exp_d);
      checkOutput("cont_i_ack", i_ack_o, !exp_d);
      tick();
      applyStimulus(1'b0, '0);
      #1;
      checkOutput("cont_gap_cs", mem_cs_o, 0);
    end
    i_cs_i = 1'b0; d_cs_i = 1'b0;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
